// File: rtl/mem_bus_master_if.sv
// Request/response handshake between the load/store unit and mem_bus_master.
// The master modport is the bus-master side; the slave modport is the
// requester (load/store unit) side.
interface mem_bus_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master: initiator on the shared data-memory bus.
// Takes one load/store at a time from the load/store unit, drives the
// address bus, owns data_bus only while writing, captures synchronous-read
// data one cycle after addressing, and returns a one-cycle response.
// Optional feature: define MEM_MASTER_WRITE_VERIFY_EN to read back every
// store and flag a mismatch in resp_err.
module mem_bus_master #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_bus_master_if.master     bus,
  output logic [ADDR_W-1:0]    address_bus,
  inout  wire  [DATA_W-1:0]    data_bus,
  output logic                 write_mode
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] wdata_r;
  logic [ADDR_W-1:0] address_bus_r;
  logic              write_mode_r;
  logic              req_ready_r;
  logic              resp_valid_r;
  logic              resp_err_r;
  logic [DATA_W-1:0] resp_rdata_r;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
  logic              write_r;
`endif

  assign address_bus    = address_bus_r;
  assign write_mode     = write_mode_r;
  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;

  // The master drives data_bus only in WR; otherwise the memory owns it.
  assign data_bus = write_mode_r ? wdata_r : {DATA_W{1'bz}};

  // Transaction FSM with all outputs registered; async reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      wdata_r       <= {DATA_W{1'b0}};
      address_bus_r <= {ADDR_W{1'b0}};
      write_mode_r  <= 1'b0;
      req_ready_r   <= 1'b1;
      resp_valid_r  <= 1'b0;
      resp_err_r    <= 1'b0;
      resp_rdata_r  <= {DATA_W{1'b0}};
`ifdef MEM_MASTER_WRITE_VERIFY_EN
      write_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          // req_ready is high throughout IDLE, so req_valid alone means accept.
          if (bus.req_valid) begin
            wdata_r     <= bus.req_wdata;
            req_ready_r <= 1'b0;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
            write_r     <= bus.req_write;
`endif
            if (bus.req_addr[0]) begin
              // Misaligned: answer with an error, leave the memory bus alone.
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
            end else begin
              address_bus_r <= bus.req_addr;
              if (bus.req_write) begin
                state_r      <= WR;
                write_mode_r <= 1'b1;
              end else begin
                state_r <= RD_ADDR;
              end
            end
          end
        end
        WR: begin
          write_mode_r <= 1'b0;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
          // Read the just-written word back from the same address.
          state_r <= RD_ADDR;
`else
          state_r      <= RESP;
          resp_valid_r <= 1'b1;
          resp_err_r   <= 1'b0;
`endif
        end
        RD_ADDR: begin
          // Memory registers the address at the end of this cycle.
          state_r <= RD_DATA;
        end
        RD_DATA: begin
          resp_rdata_r <= data_bus;
          state_r      <= RESP;
          resp_valid_r <= 1'b1;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
          resp_err_r   <= write_r && (data_bus != wdata_r);
`else
          resp_err_r   <= 1'b0;
`endif
        end
        RESP: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          req_ready_r  <= 1'b1;
        end
        default: begin
          state_r      <= IDLE;
          write_mode_r <= 1'b0;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          req_ready_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule
